mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the integer execution unit.
- Handles all four RV-M multiply flavours: MUL, MULH, MULHSU and MULHU.
- Uses a valid/ready handshake on both sides, with backpressure, flush and a transaction tag carried alongside each operation.
- Datapath: radix-4 (2-bit) partial-product generation, then a registered binary reduction tree, then conditional negation and result select.

Parameters:
- WIDTH, 32: operand width; power of two, 8 to 64.
- TAG_W, 5: width of the tag passed through unchanged (e.g. destination register id).
- LAT, derived = log2(WIDTH/2): pipeline depth in cycles. LAT = 4 for WIDTH=32. Not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  drop all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- s_in  in  WIDTH  multiplicand (rs1).
- t_in  in  WIDTH  multiplier (rs2).
- tag_in  in  TAG_W  tag accompanying the operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  selected half of the product.
- product  out  2*WIDTH  full signed/unsigned product.
- tag_out  out  TAG_W  tag of the operation currently on the output.

Behaviour:
- Reset (rstn=0, asynchronous): every stage valid bit clears, so out_valid=0. result, product and tag_out read 0. in_ready=1 the first cycle after release. Reset asserted mid-operation discards all in-flight work; no output is produced for it.
- Stage 1 (on acceptance, i.e. in_valid && in_ready):
  - s is treated as signed for ops 01 and 10.
  - t is treated as signed for op 01 only.
  - Negative operands are replaced by their two's-complement magnitude. The most negative value becomes 2^(WIDTH-1) as unsigned, which is correct.
  - sign = s_neg XOR t_neg, masked by the signedness rules above.
  - WIDTH/2 partial products are formed, each 2*WIDTH wide: pp[i] = s*t[2i] + (s<<1)*t[2i+1].
- Reduction: level k combines pairs, arr[k][j] = arr[k-1][2j] + (arr[k-1][2j+1] << 2^k). Each level is registered.
- Final level: the last addition, then negate the sum if sign=1.
  - product = the full 2*WIDTH-bit result.
  - result = product[WIDTH-1:0] for op 00; product[2*WIDTH-1:WIDTH] otherwise.
- op and tag propagate through the pipeline alongside each stage's valid bit.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+LAT, with no stalls. Throughput is one operation per cycle.
- Stall: stall = out_valid && !out_ready.
  - While stalled, every pipeline register holds, including bubbles.
  - in_ready = !stall, combinational.
  - The output is held stable until accepted.
- Bubbles are not compressed. Order is strictly FIFO.
- Flush (synchronous): on an edge with flush=1, all stage valid bits clear, including the output stage.
  - in_ready is forced 0 while flush=1; no input is accepted that cycle.
  - Flush overrides stall.
- Simultaneous accept and retire are permitted every cycle.
- Data registers may update freely when their valid bit is 0. Only the valid bits need reset.

Optional Feature:
- Macro: MUL_MIXED_SIGN_EN.
- Defined: op 10 (MULHSU) is supported as specified above.
- Undefined: the signedness logic reduces to a single is_signed = (op==01) applied to both operands. op 10 then behaves exactly as op 11 (MULHU), and the extra sign-mask logic is removed.

Test Plan (WIDTH=32, TAG_W=5):
- MUL, s=7, t=6, tag=3, out_ready=1 -> exactly 4 cycles later: out_valid=1, result=0x0000002A, product=0x2A, tag_out=3.
- MULH, s=t=0x80000000 -> product=0x40000000_00000000, result=0x40000000. MUL with the same operands -> result=0.
- MULHSU, s=0xFFFFFFFF, t=0xFFFFFFFF -> product=0xFFFFFFFF_00000001, result=0xFFFFFFFF. With the macro undefined -> result=0xFFFFFFFE.
- MULHU, s=t=0xFFFFFFFF -> product=0xFFFFFFFE_00000001, result=0xFFFFFFFE.
- Issue 6 back-to-back ops with tags 0..5 and hold out_ready=0 for 3 cycles once the first result appears -> in_ready=0 during the stall, the output is held stable, and all 6 results arrive in tag order with no loss or duplication.
- Issue 3 ops, assert flush 2 cycles later, then issue 1 new op -> only the new op emerges, 4 cycles after its acceptance. Repeat using rstn low mid-flight instead of flush -> out_valid=0 immediately and no stale result is ever produced.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined RV-M multiplier (MUL/MULH/MULHSU/MULHU).
// Radix-4 partial products are registered on accept. A registered binary
// reduction tree follows, and the last level adds, negates and selects the
// result half. Latency is LAT = log2(WIDTH/2) cycles, with one op per cycle.
//
// Optional feature macro: MUL_MIXED_SIGN_EN
//   defined   : op 10 (MULHSU) treats s as signed and t as unsigned.
//   undefined : op 01 alone is signed; op 10 behaves as op 11 (MULHU).
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   flush                drop all in-flight operations (synchronous)
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   op, s_in, t_in       operation select, multiplicand, multiplier
//   tag_in / tag_out     tag carried alongside each operation
//   out_valid/out_ready  output handshake
//   result, product      selected half and full 2*WIDTH product
module mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   s_in,
  input  logic [WIDTH-1:0]   t_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   tag_out
);

  localparam int unsigned NPP   = WIDTH / 2;
  localparam int unsigned LAT   = $clog2(NPP);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NNODE = 2 * NPP - 2;

  // Tree nodes of all registered levels are packed back to back; this gives
  // the first node index of level k (level 0 holds the partial products).
  function automatic int unsigned lvl_off(input int unsigned k);
    return 2 * NPP - 2 * (NPP >> k);
  endfunction

  localparam int unsigned LAST = lvl_off(LAT - 1);

  logic               w_stall;
  logic               w_s_signed;
  logic               w_t_signed;
  logic               w_s_neg;
  logic               w_t_neg;
  logic [WIDTH-1:0]   w_s_mag;
  logic [WIDTH-1:0]   w_t_mag;
  logic [PW-1:0]      w_s_ext;
  logic [PW-1:0]      w_pp [NPP];
  logic [PW-1:0]      w_sum;
  logic [PW-1:0]      w_prod;

  logic [LAT:0]       r_vld;
  logic [LAT-1:0]     r_hi;
  logic [LAT-1:0]     r_neg;
  logic [TAG_W-1:0]   r_tag [LAT];
  logic [PW-1:0]      r_node [NNODE];
  logic [PW-1:0]      r_product;
  logic [WIDTH-1:0]   r_result;
  logic [TAG_W-1:0]   r_tag_out;

  // Whole pipeline freezes while the output is presented but not taken.
  assign w_stall  = r_vld[LAT] && !out_ready;
  assign in_ready = !w_stall && !flush;

  // Operand signedness.
`ifdef MUL_MIXED_SIGN_EN
  assign w_s_signed = (op == 2'b01) || (op == 2'b10);
  assign w_t_signed = (op == 2'b01);
`else
  assign w_s_signed = (op == 2'b01);
  assign w_t_signed = w_s_signed;
`endif

  // Magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  assign w_s_neg = w_s_signed && s_in[WIDTH-1];
  assign w_t_neg = w_t_signed && t_in[WIDTH-1];
  assign w_s_mag = w_s_neg ? (~s_in + WIDTH'(1)) : s_in;
  assign w_t_mag = w_t_neg ? (~t_in + WIDTH'(1)) : t_in;
  assign w_s_ext = {{WIDTH{1'b0}}, w_s_mag};

  // Radix-4 partial products, unshifted; weight of w_pp[i] is 4^i.
  always_comb begin
    for (int unsigned i = 0; i < NPP; i++) begin
      w_pp[i] = (w_t_mag[2*i]   ? w_s_ext         : '0)
              + (w_t_mag[2*i+1] ? (w_s_ext << 1)  : '0);
    end
  end

  // Final tree level: last addition, sign fix-up.
  assign w_sum  = r_node[LAST] + (r_node[LAST+1] << NPP);
  assign w_prod = r_neg[LAT-1] ? (~w_sum + PW'(1)) : w_sum;

  // Datapath and side-band registers; contents are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      for (int unsigned i = 0; i < NPP; i++) begin
        r_node[i] <= w_pp[i];
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        for (int unsigned j = 0; j < (NPP >> k); j++) begin
          r_node[lvl_off(k) + j] <= r_node[lvl_off(k-1) + 2*j]
                                  + (r_node[lvl_off(k-1) + 2*j + 1] << (1 << k));
        end
      end
      r_hi[0]  <= (op != 2'b00);
      r_neg[0] <= w_s_neg ^ w_t_neg;
      r_tag[0] <= tag_in;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_hi[k]  <= r_hi[k-1];
        r_neg[k] <= r_neg[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Valid chain and output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld     <= '0;
      r_product <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      if (flush) begin
        r_vld <= '0;
      end else if (!w_stall) begin
        r_vld <= {r_vld[LAT-1:0], in_valid};
      end
      if (!w_stall && r_vld[LAT-1]) begin
        r_product <= w_prod;
        r_result  <= r_hi[LAT-1] ? w_prod[PW-1:WIDTH] : w_prod[WIDTH-1:0];
        r_tag_out <= r_tag[LAT-1];
      end
    end
  end

  assign out_valid = r_vld[LAT];
  assign product   = r_product;
  assign result    = r_result;
  assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_mul_pipe.sv
`timescale 1ns/1ps
module tb_mul_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned TW  = 5;
  localparam int          LAT = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  s_in = '0;
  logic [W-1:0]  t_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [2*W-1:0] product;
  logic [TW-1:0] tag_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_acc = 1'b0;
  bit prev_stall = 1'b0;

  typedef struct {
    logic [W-1:0]   res;
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
  } exp_t;

  exp_t          q[$];
  logic [TW-1:0] ret_tags[$];

  mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .s_in(s_in), .t_in(t_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .product(product), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit multiply.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] s,
                                 input logic [W-1:0] t, input logic [TW-1:0] tg);
    exp_t   m;
    bit     s_sg, t_sg;
    longint sv, tv;
    logic [63:0] p;
`ifdef MUL_MIXED_SIGN_EN
    s_sg = (o == 2'b01) || (o == 2'b10);
`else
    s_sg = (o == 2'b01);
`endif
    t_sg = (o == 2'b01);
    sv = s_sg ? longint'($signed(s)) : longint'({32'b0, s});
    tv = t_sg ? longint'($signed(t)) : longint'({32'b0, t});
    p = 64'(sv * tv);
    m.prod = p;
    m.res  = (o == 2'b00) ? p[31:0] : p[63:32];
    m.tag  = tg;
    return m;
  endfunction

  function automatic logic [W-1:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // One clock: scoreboard work at the negedge, return 1ns after the posedge.
  task automatic cycle_step();
    exp_t e;
    bit   exp_rdy;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rstn) begin
      check("rst_valid", 64'(out_valid), 64'd0);
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_valid", 64'(out_valid), 64'd1);
      exp_rdy = !(out_valid && !out_ready) && !flush;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check("result",  64'(result),  64'(q[0].res));
          check("product", product,      q[0].prod);
          check("tag_out", 64'(tag_out), 64'(q[0].tag));
          if (out_ready) begin
            e = q.pop_front();
            ret_tags.push_back(e.tag);
          end
        end
      end
      last_acc = in_valid && in_ready;
      if (flush) q.delete();
      else if (last_acc) q.push_back(model(op, s_in, t_in, tag_in));
      prev_stall = out_valid && !out_ready && !flush;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] s,
                       input logic [W-1:0] t, input logic [TW-1:0] tg);
    op = o; s_in = s; t_in = t; tag_in = tg; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      cycle_step();
      if (last_acc) break;
    end
    check("issue_accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() > 0; n++) cycle_step();
    check("drain_empty", 64'(q.size()), 64'd0);
    repeat (6) cycle_step();
  endtask

  task automatic run_one(input string nm, input logic [1:0] o, input logic [W-1:0] s,
                         input logic [W-1:0] t, input logic [TW-1:0] tg,
                         input logic [W-1:0] er, input logic [63:0] ep);
    int lat;
    lat = -1;
    out_ready = 1'b1;
    issue(o, s, t, tg);
    for (int n = 1; n <= 20; n++) begin
      cycle_step();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({nm, "_latency"}, 64'(lat), 64'(LAT));
    if (lat > 0) begin
      check({nm, "_result"},  64'(result), 64'(er));
      check({nm, "_product"}, product, ep);
      check({nm, "_tag"},     64'(tag_out), 64'(tg));
    end
  endtask

  task automatic stall_test();
    int nxt, stall_left;
    bit seen;
    nxt = 0; stall_left = 3; seen = 1'b0;
    ret_tags.delete();
    for (int c = 0; c < 60 && (nxt < 6 || q.size() > 0); c++) begin
      if (nxt < 6) begin
        in_valid = 1'b1; op = 2'($urandom_range(0, 3));
        s_in = pick_opnd(); t_in = pick_opnd(); tag_in = TW'(nxt);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(seen && stall_left > 0);
      if (!out_ready) begin
        stall_left--;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      cycle_step();
      if (last_acc) nxt++;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_count", 64'(ret_tags.size()), 64'd6);
    for (int i = 0; i < ret_tags.size(); i++) check("stall_order", 64'(ret_tags[i]), 64'(i));
  endtask

  task automatic flush_test();
    ret_tags.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(2'(i), $urandom(), $urandom(), TW'(20 + i));
    flush = 1'b1; in_valid = 1'b1; tag_in = 5'd31;
    cycle_step();
    check("flush_no_accept", 64'(last_acc), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    run_one("post_flush", 2'b00, 32'd3, 32'd5, 5'd9, 32'd15, 64'd15);
    drain();
    check("flush_count", 64'(ret_tags.size()), 64'd1);
    if (ret_tags.size() > 0) check("flush_tag", 64'(ret_tags[0]), 64'd9);
  endtask

  task automatic reset_test();
    bit seen;
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(2'b11, $urandom(), $urandom(), TW'(10 + i));
    out_ready = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle_step();
      seen = out_valid;
    end
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    q.delete();
    prev_stall = 1'b0;
    repeat (2) cycle_step();
    rstn = 1'b1;
    out_ready = 1'b1;
    ret_tags.delete();
    repeat (8) cycle_step();
    check("rst_no_stale", 64'(ret_tags.size()), 64'd0);
  endtask

  initial begin
    repeat (3) cycle_step();
    check("rst_result",  64'(result), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_tag",     64'(tag_out), 64'd0);
    rstn = 1'b1;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    run_one("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'h0000_002A, 64'h2A);
    run_one("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4,
            32'h4000_0000, 64'h4000_0000_0000_0000);
    run_one("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd5,
            32'h0000_0000, 64'h4000_0000_0000_0000);
`ifdef MUL_MIXED_SIGN_EN
    run_one("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
            32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
`else
    run_one("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
            32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
`endif
    run_one("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
            32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
    run_one("mulh_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 5'd8,
            32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1);
    drain();

    stall_test();
    drain();
    flush_test();
    reset_test();

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 2'($urandom_range(0, 3));
      s_in      = pick_opnd();
      t_in      = pick_opnd();
      tag_in    = TW'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      cycle_step();
    end
    flush = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
